// File: rtl/uart_tx_serializer.sv
// UART transmitter: accepts one word per valid/ready handshake and serializes it as
// start, 5-8 data bits LSB first, optional parity and 1-2 stop bits.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIV_WIDTH-1:0]  baudDivisor,
  input  logic [4:0]            overSampling,
  input  logic [3:0]            dataType,
  input  logic                  parityEnable,
  input  logic                  parityType,
  input  logic [1:0]            stopBits,
  input  logic [DATA_WIDTH-1:0] txData,
  input  logic                  txValid,
  output logic                  txReady,
  output logic                  tx,
  output logic                  busy,
  output logic                  txDone
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_reg, state_next;
  logic [DIV_WIDTH-1:0]  div_reg, div_next, div_cnt_reg, div_cnt_next;
  logic [4:0]            os_reg, os_next, tick_cnt_reg, tick_cnt_next;
  logic [3:0]            nbits_reg, nbits_next, bit_idx_reg, bit_idx_next;
  logic                  par_en_reg, par_en_next, par_bit_reg, par_bit_next;
  logic                  stop2_reg, stop2_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;

  logic [DIV_WIDTH-1:0]  div_norm;
  logic [4:0]            os_norm;
  logic [3:0]            nbits_norm;
  logic [DATA_WIDTH-1:0] data_mask;
  logic                  par_norm;
  logic                  tick, bit_end;

  assign div_norm   = (baudDivisor == '0) ? DIV_WIDTH'(1) : baudDivisor;
  assign os_norm    = (overSampling == 5'd13) ? 5'd13 : 5'd16;
  assign nbits_norm = (dataType < 4'd5) ? 4'd5 : ((dataType > 4'd8) ? 4'd8 : dataType);

  // Only the bits that will actually be shifted out contribute to parity.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_mask
      assign data_mask[gi] = (gi < int'(nbits_norm));
    end
  endgenerate

  assign par_norm = (^(txData & data_mask)) ^ parityType;

  assign tick    = (div_cnt_reg == div_reg - DIV_WIDTH'(1));
  assign bit_end = tick && (tick_cnt_reg == os_reg - 5'd1);

  assign txReady = (state_reg == IDLE) && reset;
  assign busy    = (state_reg != IDLE);
  assign txDone  = (state_reg == STOP) && bit_end && (bit_idx_reg[0] == stop2_reg);

  always_comb begin
    tx = 1'b1;
    case (state_reg)
      START:   tx = 1'b0;
      DATA:    tx = shift_reg[0];
      PARITY:  tx = par_bit_reg;
      default: tx = 1'b1;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    div_next      = div_reg;
    os_next       = os_reg;
    nbits_next    = nbits_reg;
    par_en_next   = par_en_reg;
    par_bit_next  = par_bit_reg;
    stop2_next    = stop2_reg;
    shift_next    = shift_reg;
    bit_idx_next  = bit_idx_reg;
    div_cnt_next  = div_cnt_reg;
    tick_cnt_next = tick_cnt_reg;

    if (state_reg != IDLE) begin
      div_cnt_next  = tick ? '0 : div_cnt_reg + DIV_WIDTH'(1);
      tick_cnt_next = bit_end ? '0 : (tick ? tick_cnt_reg + 5'd1 : tick_cnt_reg);
    end

    case (state_reg)
      IDLE: begin
        if (txValid && txReady) begin
          state_next    = START;
          div_next      = div_norm;
          os_next       = os_norm;
          nbits_next    = nbits_norm;
          par_en_next   = parityEnable;
          par_bit_next  = par_norm;
          stop2_next    = (stopBits == 2'd2);
          shift_next    = txData;
          bit_idx_next  = '0;
          div_cnt_next  = '0;
          tick_cnt_next = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_next   = DATA;
          bit_idx_next = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (bit_idx_reg == nbits_reg - 4'd1) begin
            bit_idx_next = '0;
            state_next   = par_en_reg ? PARITY : STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 4'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next   = STOP;
          bit_idx_next = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (txDone) state_next = IDLE;
          else        bit_idx_next = bit_idx_reg + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      div_reg      <= DIV_WIDTH'(1);
      os_reg       <= 5'd16;
      nbits_reg    <= 4'd8;
      par_en_reg   <= 1'b0;
      par_bit_reg  <= 1'b0;
      stop2_reg    <= 1'b0;
      shift_reg    <= '0;
      bit_idx_reg  <= '0;
      div_cnt_reg  <= '0;
      tick_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      div_reg      <= div_next;
      os_reg       <= os_next;
      nbits_reg    <= nbits_next;
      par_en_reg   <= par_en_next;
      par_bit_reg  <= par_bit_next;
      stop2_reg    <= stop2_next;
      shift_reg    <= shift_next;
      bit_idx_reg  <= bit_idx_next;
      div_cnt_reg  <= div_cnt_next;
      tick_cnt_reg <= tick_cnt_next;
    end
  end

endmodule
